// File: rtl/edge_pkg.sv
// Purpose: shared encodings and entry layout for the edge event capture block.
//   EDGE_* : EDGE_MODE encodings.
//   `EDGE_EV_ENTRY_T(MW, SW) : packed {mask, stamp} entry, sized per instance.
`ifndef EDGE_PKG_SV
`define EDGE_PKG_SV

// Entry layout macro so each instance can size mask/stamp from its own parameters.
`define EDGE_EV_ENTRY_T(MW, SW) struct packed { logic [(MW)-1:0] mask; logic [(SW)-1:0] stamp; }

package edge_pkg;

  localparam logic [1:0] EDGE_RISE = 2'd0;
  localparam logic [1:0] EDGE_FALL = 2'd1;
  localparam logic [1:0] EDGE_BOTH = 2'd2;
  localparam logic [1:0] EDGE_OFF  = 2'd3;

  localparam int unsigned DEF_WIDTH     = 8;
  localparam int unsigned DEF_CNT_WIDTH = 16;

  // Default-sized entry, used as the FIFO's default element type.
  typedef `EDGE_EV_ENTRY_T(DEF_WIDTH, DEF_CNT_WIDTH) ev_entry_t;

endpackage

`endif

// File: rtl/event_fifo.sv
// Purpose: DEPTH-entry event queue with registered head, flush and drop report.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   flush          synchronous flush; push/pop on the same edge are discarded
//   push, wr_data  offer an entry
//   pop            consumer accepts the head (ignored when empty)
//   valid, head    registered head valid / head entry (zero when empty)
//   drop_c         push refused because the queue is full with no pop
module event_fifo
  import edge_pkg::*;
#(
  parameter type         entry_t = ev_entry_t,
  parameter int unsigned DEPTH   = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   flush,
  input  logic   push,
  input  logic   pop,
  input  entry_t wr_data,
  output logic   valid,
  output entry_t head,
  output logic   drop_c
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic             full_c, do_push_c, do_pop_c;
  entry_t           head_nxt;

  // Next-state for pointers, occupancy and the registered head.
  always_comb begin
    full_c     = (count == CNT_W'(DEPTH));
    do_pop_c   = pop && (count != '0) && !flush;
    do_push_c  = push && !flush && (!full_c || do_pop_c);
    drop_c     = push && !flush && full_c && !do_pop_c;
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    count_nxt  = count;
    head_nxt   = '0;
    if (flush) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
      count_nxt  = '0;
    end else begin
      if (do_push_c) wr_ptr_nxt = wr_ptr + PTR_W'(1);
      if (do_pop_c)  rd_ptr_nxt = rd_ptr + PTR_W'(1);
      case ({do_push_c, do_pop_c})
        2'b10:   count_nxt = count + CNT_W'(1);
        2'b01:   count_nxt = count - CNT_W'(1);
        default: count_nxt = count;
      endcase
    end
    // The new head may be the entry being written this edge (queue was empty).
    if (count_nxt != '0) begin
      head_nxt = (do_push_c && (rd_ptr_nxt == wr_ptr)) ? wr_data : mem[rd_ptr_nxt];
    end
  end

  // Storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push_c) mem[wr_ptr] <= wr_data;
  end

  // Pointer, occupancy and head registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= 1'b0;
      head   <= '0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      count  <= count_nxt;
      valid  <= (count_nxt != '0);
      head   <= head_nxt;
    end
  end

endmodule

// File: rtl/edge_event_capture.sv
// Purpose: samples a level bus, turns level changes into timestamped edge
// events and queues them for a valid/ready consumer.
// Ports:
//   CLK, RESET        clock, async active-low reset
//   XIN               monitored level bus (synchronous to CLK)
//   EDGE_MODE         0 rising, 1 falling, 2 both, 3 disabled
//   CLEAR             synchronous flush of queue, OVERFLOW and timestamp
//   EV_VALID/EV_READY head handshake
//   EV_MASK/EV_STAMP  head entry (zero when empty)
//   OVERFLOW          sticky event-dropped flag
//   LEVEL             current sampled bus value
module edge_event_capture
  import edge_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [WIDTH-1:0]     XIN,
  input  logic [1:0]           EDGE_MODE,
  input  logic                 CLEAR,
  output logic                 EV_VALID,
  input  logic                 EV_READY,
  output logic [WIDTH-1:0]     EV_MASK,
  output logic [CNT_WIDTH-1:0] EV_STAMP,
  output logic                 OVERFLOW,
  output logic [WIDTH-1:0]     LEVEL
);

  typedef `EDGE_EV_ENTRY_T(WIDTH, CNT_WIDTH) entry_t;

  logic [WIDTH-1:0]     s1, s2;
  logic                 primed;
  logic [CNT_WIDTH-1:0] stamp_cnt;
  logic [WIDTH-1:0]     rise_c, fall_c, mask_c;
  logic                 push_c, drop_c;
  entry_t               wr_entry_c, head;

  // Two-stage sampler. On the priming edge both stages load XIN so the
  // zero reset value of s1 never looks like an edge.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      s1     <= '0;
      s2     <= '0;
      primed <= 1'b0;
    end else begin
      s1     <= XIN;
      s2     <= primed ? s1 : XIN;
      primed <= 1'b1;
    end
  end

  // Free-running timestamp, wraps silently.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)     stamp_cnt <= '0;
    else if (CLEAR) stamp_cnt <= '0;
    else            stamp_cnt <= stamp_cnt + CNT_WIDTH'(1);
  end

  // Edge mask selection; EDGE_MODE feeds the push decision directly.
  always_comb begin
    rise_c = s1 & ~s2;
    fall_c = ~s1 & s2;
    mask_c = '0;
    if (primed) begin
      case (EDGE_MODE)
        EDGE_RISE: mask_c = rise_c;
        EDGE_FALL: mask_c = fall_c;
        EDGE_BOTH: mask_c = rise_c | fall_c;
        default:   mask_c = '0;
      endcase
    end
    push_c           = |mask_c;
    wr_entry_c.mask  = mask_c;
    wr_entry_c.stamp = stamp_cnt;
  end

  // Sticky drop indicator.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)      OVERFLOW <= 1'b0;
    else if (CLEAR)  OVERFLOW <= 1'b0;
    else if (drop_c) OVERFLOW <= 1'b1;
  end

  event_fifo #(
    .entry_t (entry_t),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk     (CLK),
    .rst_n   (RESET),
    .flush   (CLEAR),
    .push    (push_c),
    .pop     (EV_READY),
    .wr_data (wr_entry_c),
    .valid   (EV_VALID),
    .head    (head),
    .drop_c  (drop_c)
  );

  assign EV_MASK  = head.mask;
  assign EV_STAMP = head.stamp;
  assign LEVEL    = s1;

endmodule

// File: tb/tb_edge_event_capture.sv
// Directed bench for edge_event_capture (WIDTH=8, DEPTH=4, CNT_WIDTH=4).
// Edge numbers in comments count posedges after reset release, starting at 1.
module tb_edge_event_capture;

  localparam int unsigned WIDTH     = 8;
  localparam int unsigned DEPTH     = 4;
  localparam int unsigned CNT_WIDTH = 4;

  logic                 CLK;
  logic                 RESET;
  logic [WIDTH-1:0]     XIN;
  logic [1:0]           EDGE_MODE;
  logic                 CLEAR;
  logic                 EV_VALID;
  logic                 EV_READY;
  logic [WIDTH-1:0]     EV_MASK;
  logic [CNT_WIDTH-1:0] EV_STAMP;
  logic                 OVERFLOW;
  logic [WIDTH-1:0]     LEVEL;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] ovf_xin   [5] = '{8'hF1, 8'hF3, 8'hF7, 8'hFF, 8'hEF};
  logic [7:0] drain_msk [4] = '{8'h02, 8'h04, 8'h08, 8'h02};
  logic [3:0] drain_stp [4] = '{4'h9, 4'hA, 4'hB, 4'hE};
  logic [7:0] clr_xin   [4] = '{8'hEC, 8'hEE, 8'hEA, 8'hE2};

  edge_event_capture #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .XIN       (XIN),
    .EDGE_MODE (EDGE_MODE),
    .CLEAR     (CLEAR),
    .EV_VALID  (EV_VALID),
    .EV_READY  (EV_READY),
    .EV_MASK   (EV_MASK),
    .EV_STAMP  (EV_STAMP),
    .OVERFLOW  (OVERFLOW),
    .LEVEL     (LEVEL)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RESET     = 1'b1;
    XIN       = 8'hFF;
    EDGE_MODE = 2'd2;
    CLEAR     = 1'b0;
    EV_READY  = 1'b0;
    #2 RESET  = 1'b0;
    repeat (3) tick();
    check("rst_valid", 32'(EV_VALID), 32'h0);
    check("rst_mask",  32'(EV_MASK),  32'h0);
    check("rst_stamp", 32'(EV_STAMP), 32'h0);
    check("rst_ovf",   32'(OVERFLOW), 32'h0);
    check("rst_level", 32'(LEVEL),    32'h0);
    RESET = 1'b1;

    // Reset-prime: steady FF must not look like an edge.
    for (int i = 0; i < 4; i++) begin
      tick();                                   // edges 1..4
      check("prime_novalid", 32'(EV_VALID), 32'h0);
    end
    check("prime_level", 32'(LEVEL), 32'hFF);

    // Rising mode.
    XIN = 8'h00; EDGE_MODE = 2'd0;
    tick(); tick();                             // edges 5,6 (fall ignored)
    check("rise_nofall", 32'(EV_VALID), 32'h0);
    XIN = 8'h05;
    tick();                                     // edge 7 samples
    check("rise_latency", 32'(EV_VALID), 32'h0);
    tick();                                     // edge 8 pushes
    check("rise_valid", 32'(EV_VALID), 32'h1);
    check("rise_mask",  32'(EV_MASK),  32'h05);
    check("rise_stamp", 32'(EV_STAMP), 32'h7);
    EV_READY = 1'b1;
    tick();                                     // edge 9 pops
    check("rise_pop", 32'(EV_VALID), 32'h0);

    // Park at 0F with edges disabled.
    XIN = 8'h0F; EDGE_MODE = 2'd3;
    tick(); tick();                             // edges 10,11
    check("off_settle", 32'(EV_VALID), 32'h0);

    // Both edges.
    EDGE_MODE = 2'd2; XIN = 8'hF0;
    tick(); tick();                             // edges 12,13
    check("both1_valid", 32'(EV_VALID), 32'h1);
    check("both1_mask",  32'(EV_MASK),  32'hFF);
    check("both1_stamp", 32'(EV_STAMP), 32'hC);
    XIN = 8'h0F;
    tick();                                     // edge 14
    check("both_gap", 32'(EV_VALID), 32'h0);
    tick();                                     // edge 15
    check("both2_mask",  32'(EV_MASK),  32'hFF);
    check("both2_stamp", 32'(EV_STAMP), 32'hE);

    // Falling mode, stamps wrap past 15.
    EDGE_MODE = 2'd1; XIN = 8'hF0;
    tick();                                     // edge 16
    check("fall_gap1", 32'(EV_VALID), 32'h0);
    tick();                                     // edge 17
    check("fall1_valid", 32'(EV_VALID), 32'h1);
    check("fall1_mask",  32'(EV_MASK),  32'h0F);
    check("fall1_stamp", 32'(EV_STAMP), 32'h0);
    XIN = 8'h0F;
    tick();                                     // edge 18
    check("fall_gap2", 32'(EV_VALID), 32'h0);
    tick();                                     // edge 19
    check("fall2_mask",  32'(EV_MASK),  32'hF0);
    check("fall2_stamp", 32'(EV_STAMP), 32'h2);

    // Disabled mode: toggling yields nothing.
    EDGE_MODE = 2'd3; XIN = 8'hF0;
    tick();                                     // edge 20
    check("off_0", 32'(EV_VALID), 32'h0);
    XIN = 8'h0F;
    tick();                                     // edge 21
    check("off_1", 32'(EV_VALID), 32'h0);
    XIN = 8'hF0;
    tick();                                     // edge 22
    check("off_2", 32'(EV_VALID), 32'h0);
    tick();                                     // edge 23
    check("off_3", 32'(EV_VALID), 32'h0);

    // Overflow: five edges into a four-deep queue.
    EDGE_MODE = 2'd2; EV_READY = 1'b0;
    for (int i = 0; i < 5; i++) begin
      XIN = ovf_xin[i];
      tick();                                   // edges 24..28
    end
    check("ovf_pre",      32'(OVERFLOW), 32'h0);
    check("ovf_pre_vld",  32'(EV_VALID), 32'h1);
    tick();                                     // edge 29 drops mask 10
    check("ovf_set",      32'(OVERFLOW), 32'h1);
    check("ovf_head_msk", 32'(EV_MASK),  32'h01);
    check("ovf_head_stp", 32'(EV_STAMP), 32'h8);
    XIN = 8'hED;
    tick();                                     // edge 30 samples
    EV_READY = 1'b1;
    tick();                                     // edge 31 push + pop while full
    check("ovf_hold", 32'(OVERFLOW), 32'h1);
    for (int i = 0; i < 4; i++) begin
      check("drain_valid", 32'(EV_VALID), 32'h1);
      check("drain_mask",  32'(EV_MASK),  32'(drain_msk[i]));
      check("drain_stamp", 32'(EV_STAMP), 32'(drain_stp[i]));
      tick();                                   // edges 32..35
    end
    check("drain_empty",  32'(EV_VALID), 32'h0);
    check("ovf_sticky",   32'(OVERFLOW), 32'h1);

    // CLEAR with three queued entries and an edge on the same clock.
    EV_READY = 1'b0;
    for (int i = 0; i < 4; i++) begin
      XIN = clr_xin[i];
      tick();                                   // edges 36..39
    end
    check("clr_pre_vld", 32'(EV_VALID), 32'h1);
    check("clr_pre_msk", 32'(EV_MASK),  32'h01);
    check("clr_pre_stp", 32'(EV_STAMP), 32'h4);
    CLEAR = 1'b1; XIN = 8'hE3;
    tick();                                     // edge 40 flush
    CLEAR = 1'b0;
    check("clr_valid", 32'(EV_VALID), 32'h0);
    check("clr_ovf",   32'(OVERFLOW), 32'h0);
    check("clr_mask",  32'(EV_MASK),  32'h0);
    tick();                                     // edge 41
    check("clr_next_vld", 32'(EV_VALID), 32'h1);
    check("clr_next_msk", 32'(EV_MASK),  32'h01);
    check("clr_next_stp", 32'(EV_STAMP), 32'h0);
    EV_READY = 1'b1;
    tick();                                     // edge 42
    check("clr_drained", 32'(EV_VALID), 32'h0);
    EV_READY = 1'b0;

    // Timestamp wrap: pushes at counts 15 and 0.
    repeat (12) tick();                         // edges 43..54
    XIN = 8'hE7;
    tick();                                     // edge 55
    XIN = 8'hE6;
    tick(); tick();                             // edges 56,57
    check("wrap1_vld", 32'(EV_VALID), 32'h1);
    check("wrap1_msk", 32'(EV_MASK),  32'h04);
    check("wrap1_stp", 32'(EV_STAMP), 32'hF);
    EV_READY = 1'b1;
    tick();                                     // edge 58
    check("wrap2_vld", 32'(EV_VALID), 32'h1);
    check("wrap2_msk", 32'(EV_MASK),  32'h01);
    check("wrap2_stp", 32'(EV_STAMP), 32'h0);

    // Async reset between edges.
    #2 RESET = 1'b0;
    #1;
    check("areset_vld",   32'(EV_VALID), 32'h0);
    check("areset_msk",   32'(EV_MASK),  32'h0);
    check("areset_stp",   32'(EV_STAMP), 32'h0);
    check("areset_level", 32'(LEVEL),    32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
    $finish;
  end

endmodule
